metacognition_mc: RTL and testbench
===================================

Name: metacognition_mc

Overview:
- Multi-channel, parametrised successor to the single-stream exploit/explore monitor.
- Tracks NCH episodic-memory channels, each with its own confidence register. A quorum vote across channels drives a registered three-state mode FSM with dwell hysteresis.
- Prediction-error streaks and input mismatch force EXPLORE immediately.
- Sits between the episodic-memory bank and the context gate / learning-rate controller.

Parameters:
NCH, 4, number of episodic channels
SW, 4, ep_strength width per channel
EW, 8, pred_err width
EXPLOIT_THR, 6, strength >= this marks a channel confident
EXPLORE_THR, 5, strength <= this marks a channel uncertain (EXPLORE_THR < EXPLOIT_THR)
ERR_HIGH_THR, 50, pred_err strictly above this counts as a miss
ERR_FORCE_WIN, 5, consecutive misses that force EXPLORE
Q_EXPLOIT, 3, confident channels needed for the EXPLOIT candidate
Q_EXPLORE, 2, uncertain channels needed for the EXPLORE candidate
DWELL, 3, minimum evaluations spent in a state before a voluntary exit
DECAY_TICKS, 8, idle theta ticks before confidence decay (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
theta_tick  in  1  theta-cycle strobe
cyc_start  in  1  gamma-cycle start strobe
ep_strength  in  NCH*SW  packed per-channel strength; channel i at [i*SW +: SW]
ep_valid  in  NCH  per-channel valid
pred_err  in  EW  prediction error
input_mismatch  in  1  early input-pattern mismatch
mode  out  2  0=NEUTRAL, 1=EXPLOIT, 2=EXPLORE
exploit_mode  out  1  mode==EXPLOIT
explore_mode  out  1  mode==EXPLORE
confidence_level  out  NCH*2  packed per-channel 2-bit confidence
err_explore  out  1  error-streak force active
mode_change  out  1  one-cycle pulse on any mode transition
worst_ch  out  clog2(NCH)  lowest-strength valid channel, latched at evaluation

Behaviour:
- Reset: synchronous. With rst_n=0 at a rising edge, all registers clear: mode=NEUTRAL, all confidence=0, err counter=0, dwell=0, worst_ch=0, mode_change=0, tick_d=0. Reset asserted mid-operation wins over every other event in that cycle.
- Per-channel confidence update: on theta_tick with ep_valid[i]=1:
  - strength >= EXPLOIT_THR: conf=3.
  - strength <= EXPLORE_THR: conf=2 if the old value was 3, else conf=1.
  - Otherwise: conf=2.
  - Channels with ep_valid[i]=0 hold their value.
- Error counter: updates on cyc_start only.
  - pred_err > ERR_HIGH_THR: increment, saturating at ERR_FORCE_WIN.
  - Otherwise: clear to 0.
  - err_forced = (count >= ERR_FORCE_WIN). err_explore is the registered err_forced.
- Evaluation strobe: tick_d is theta_tick delayed one cycle, so votes use the updated confidences.
- Votes, computed at tick_d:
  - n_conf = number of channels with ep_valid=1 and conf==3.
  - n_unc = number of channels with ep_valid=1, strength <= EXPLORE_THR and conf <= 2.
  - cand_explore = n_unc >= Q_EXPLORE.
  - cand_exploit = (n_conf >= Q_EXPLOIT) && !cand_explore.
- Forced path: err_forced or input_mismatch in any cycle puts mode=EXPLORE at the next edge. This ignores dwell and the tick. dwell is reset to 0 on the forced entry, or held at 0 if already in EXPLORE.
- Voluntary transitions, at tick_d with no force active:
  - If dwell < DWELL: dwell increments (saturating) and mode holds.
  - Otherwise the target is EXPLORE if cand_explore, else EXPLOIT if cand_exploit, else NEUTRAL.
  - A changed target clears dwell. An unchanged target leaves dwell saturated.
- mode_change is high exactly one cycle after any edge where mode changed, including forced entries.
- worst_ch: latched at tick_d as the minimum-strength valid channel; ties go to the lower index. Holds if no channel is valid.
- Simultaneous events:
  - theta_tick together with cyc_start: both are processed.
  - tick_d together with a force: the force wins.
  - Forcing while already in EXPLORE gives no mode_change pulse.
- All outputs are registered. Latency is 1 cycle from a force and 2 cycles from theta_tick.

Optional Feature:
- METACOG_DECAY_EN defined: each channel has an idle counter that counts theta_ticks with ep_valid[i]=0. When the counter reaches DECAY_TICKS, conf decrements by 1 (saturating at 0) and the counter clears. A valid tick also clears the counter.
- Not defined: no idle counters; confidence holds indefinitely.

Test Plan:
- Reset, then all 4 channels valid at strength 7 with a theta_tick: conf=3 on all channels. The first three evaluations hold NEUTRAL; at the 4th evaluation mode=EXPLOIT and mode_change pulses once.
- From EXPLOIT, pred_err=60 on 5 consecutive cyc_starts: err_explore=1 and, one cycle later, mode=EXPLORE regardless of dwell. pred_err=40 on the next cyc_start clears the counter.
- input_mismatch pulsed for 1 cycle while NEUTRAL: mode=EXPLORE at the next edge, mode_change=1 for that following cycle, dwell=0.
- Mixed strengths {7,7,4,3} after conf=3: conf becomes {3,3,2,2}, n_unc=2, so the target is EXPLORE once dwell is satisfied. worst_ch=3. Ties {4,4} give the lower index.
- Reset asserted during EXPLORE with the err counter at 3: the next cycle shows mode=0, all outputs 0, and the counter at 0.
- With METACOG_DECAY_EN defined, channel 0 idle for 8 ticks: conf 3 drops to 2. A further 16 idle ticks bring it to 0. With the macro undefined, conf stays 3.

Source files
------------

// File: rtl/metacognition_mc.sv
// metacognition_mc: multi-channel exploit/explore monitor with quorum vote and dwell hysteresis
// Ports: clk, rst_n (synchronous, active low); theta_tick and cyc_start strobes;
//   ep_strength/ep_valid per-channel episodic inputs; pred_err and input_mismatch force inputs;
//   mode/exploit_mode/explore_mode current state; confidence_level packed 2-bit per channel;
//   err_explore error-streak force flag; mode_change transition pulse; worst_ch weakest valid channel.
// Optional: define METACOG_DECAY_EN to decay idle channels' confidence every DECAY_TICKS theta ticks.
module metacognition_mc #(
    parameter int NCH = 4,
    parameter int SW = 4,
    parameter int EW = 8,
    parameter int EXPLOIT_THR = 6,
    parameter int EXPLORE_THR = 5,
    parameter int ERR_HIGH_THR = 50,
    parameter int ERR_FORCE_WIN = 5,
    parameter int Q_EXPLOIT = 3,
    parameter int Q_EXPLORE = 2,
    parameter int DWELL = 3,
`ifdef METACOG_DECAY_EN
    parameter int DECAY_TICKS = 8,
`endif
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              theta_tick,
    input  logic              cyc_start,
    input  logic [NCH*SW-1:0] ep_strength,
    input  logic [NCH-1:0]    ep_valid,
    input  logic [EW-1:0]     pred_err,
    input  logic              input_mismatch,
    output logic [1:0]        mode,
    output logic              exploit_mode,
    output logic              explore_mode,
    output logic [NCH*2-1:0]  confidence_level,
    output logic              err_explore,
    output logic              mode_change,
    output logic [CW-1:0]     worst_ch
);
    localparam int NW = $clog2(NCH + 1);
    localparam int EC = $clog2(ERR_FORCE_WIN + 1);
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [SW-1:0] HI_S = SW'(EXPLOIT_THR);
    localparam logic [SW-1:0] LO_S = SW'(EXPLORE_THR);
    localparam logic [EW-1:0] ERR_T = EW'(ERR_HIGH_THR);
    localparam logic [EC-1:0] ERR_W = EC'(ERR_FORCE_WIN);
    localparam logic [DW-1:0] DW_MAX = DW'(DWELL);
    localparam logic [NW-1:0] QX = NW'(Q_EXPLOIT);
    localparam logic [NW-1:0] QR = NW'(Q_EXPLORE);

    typedef enum logic [1:0] {NEUTRAL = 2'd0, EXPLOIT = 2'd1, EXPLORE = 2'd2} mode_t;

    mode_t         mode_q, mode_d, tgt;
    logic [1:0]    conf_q [NCH];
    logic [1:0]    conf_d [NCH];
    logic [EC-1:0] err_q, err_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] worst_q, worst_d;
    logic [NW-1:0] n_conf, n_unc;
    logic [SW-1:0] st, ws;
    logic          tick_d, found, err_forced, cand_explore, cand_exploit, mc_q, errx_q;
`ifdef METACOG_DECAY_EN
    localparam int IW = $clog2(DECAY_TICKS);
    localparam logic [IW-1:0] ID_MAX = IW'(DECAY_TICKS - 1);
    logic [IW-1:0] idle_q [NCH];
    logic [IW-1:0] idle_d [NCH];
`endif

    // Confidence update uses the strobe cycle; votes read the registered confidences one cycle later.
    always_comb begin
        n_conf = '0;
        n_unc = '0;
        worst_d = worst_q;
        ws = '0;
        st = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            st = ep_strength[i*SW +: SW];
            conf_d[i] = conf_q[i];
            if (theta_tick && ep_valid[i])
                conf_d[i] = (st >= HI_S) ? 2'd3 : (st <= LO_S) ? ((conf_q[i] == 2'd3) ? 2'd2 : 2'd1) : 2'd2;
`ifdef METACOG_DECAY_EN
            idle_d[i] = idle_q[i];
            if (theta_tick)
                idle_d[i] = (ep_valid[i] || idle_q[i] == ID_MAX) ? '0 : idle_q[i] + 1'b1;
            if (theta_tick && !ep_valid[i] && idle_q[i] == ID_MAX)
                conf_d[i] = (conf_q[i] == 2'd0) ? 2'd0 : conf_q[i] - 2'd1;
`endif
            if (ep_valid[i]) begin
                n_conf = n_conf + NW'(conf_q[i] == 2'd3);
                n_unc = n_unc + NW'(st <= LO_S && conf_q[i] <= 2'd2);
                // strict compare keeps the lower index on ties
                if (!found || st < ws) begin
                    ws = st;
                    worst_d = CW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign err_forced = err_q >= ERR_W;
    assign cand_explore = n_unc >= QR;
    assign cand_exploit = (n_conf >= QX) && !cand_explore;
    assign tgt = cand_explore ? EXPLORE : cand_exploit ? EXPLOIT : NEUTRAL;
    assign err_d = !cyc_start ? err_q : (pred_err <= ERR_T) ? '0 : (err_q == ERR_W) ? err_q : err_q + 1'b1;

    always_comb begin
        mode_d = mode_q;
        dwell_d = dwell_q;
        if (err_forced || input_mismatch) begin
            mode_d = EXPLORE;
            dwell_d = '0;
        end else if (tick_d) begin
            if (dwell_q < DW_MAX) begin
                dwell_d = dwell_q + 1'b1;
            end else if (tgt != mode_q) begin
                mode_d = tgt;
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= NEUTRAL;
            conf_q <= '{default: '0};
            err_q <= '0;
            dwell_q <= '0;
            worst_q <= '0;
            tick_d <= 1'b0;
            mc_q <= 1'b0;
            errx_q <= 1'b0;
`ifdef METACOG_DECAY_EN
            idle_q <= '{default: '0};
`endif
        end else begin
            mode_q <= mode_d;
            conf_q <= conf_d;
            err_q <= err_d;
            dwell_q <= dwell_d;
            worst_q <= tick_d ? worst_d : worst_q;
            tick_d <= theta_tick;
            mc_q <= mode_d != mode_q;
            errx_q <= err_forced;
`ifdef METACOG_DECAY_EN
            idle_q <= idle_d;
`endif
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_conf
        assign confidence_level[i*2 +: 2] = conf_q[i];
    end

    assign mode = mode_q;
    assign exploit_mode = mode_q == EXPLOIT;
    assign explore_mode = mode_q == EXPLORE;
    assign err_explore = errx_q;
    assign mode_change = mc_q;
    assign worst_ch = worst_q;
endmodule

// File: tb/tb_metacognition_mc.sv
// tb_metacognition_mc: directed bench with a cycle model and literal anchor checks
module tb_metacognition_mc;
    logic        clk = 1'b0;
    logic        rst_n, theta_tick, cyc_start, input_mismatch;
    logic [15:0] ep_strength;
    logic [3:0]  ep_valid;
    logic [7:0]  pred_err;
    logic [1:0]  mode;
    logic        exploit_mode, explore_mode, err_explore, mode_change;
    logic [7:0]  confidence_level;
    logic [1:0]  worst_ch;

    int total = 0;
    int bad = 0;

    metacognition_mc dut (
        .clk(clk), .rst_n(rst_n), .theta_tick(theta_tick), .cyc_start(cyc_start),
        .ep_strength(ep_strength), .ep_valid(ep_valid), .pred_err(pred_err),
        .input_mismatch(input_mismatch), .mode(mode), .exploit_mode(exploit_mode),
        .explore_mode(explore_mode), .confidence_level(confidence_level),
        .err_explore(err_explore), .mode_change(mode_change), .worst_ch(worst_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int str(input int i);
        return int'((ep_strength >> (i * 4)) & 16'hF);
    endfunction

    // Reference model: integer state advanced once per rising edge from the rules.
    int m_conf[4];
    int m_idle[4];
    int m_err = 0, m_dwell = 0, m_mode = 0, m_mc = 0, m_tickd = 0, m_worst = 0, m_errx = 0;
    bit started = 0;

    always @(posedge clk) begin
        int nc, nu, ws, nmode, ndw, tgt;
        started = 1;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_conf[i] = 0;
                m_idle[i] = 0;
            end
            m_err = 0; m_dwell = 0; m_mode = 0; m_mc = 0; m_tickd = 0; m_worst = 0; m_errx = 0;
        end else begin
            nmode = m_mode;
            ndw = m_dwell;
            if (m_err >= 5 || input_mismatch) begin
                nmode = 2;
                ndw = 0;
            end else if (m_tickd != 0) begin
                nc = 0;
                nu = 0;
                for (int i = 0; i < 4; i++)
                    if (ep_valid[i]) begin
                        if (m_conf[i] == 3) nc++;
                        if (str(i) <= 5 && m_conf[i] <= 2) nu++;
                    end
                if (m_dwell < 3) ndw = m_dwell + 1;
                else begin
                    tgt = (nu >= 2) ? 2 : (nc >= 3) ? 1 : 0;
                    if (tgt != m_mode) begin
                        nmode = tgt;
                        ndw = 0;
                    end
                end
            end
            if (m_tickd != 0) begin
                ws = 99;
                for (int i = 0; i < 4; i++)
                    if (ep_valid[i] && str(i) < ws) begin
                        ws = str(i);
                        m_worst = i;
                    end
            end
            m_mc = (nmode != m_mode) ? 1 : 0;
            m_mode = nmode;
            m_dwell = ndw;
            m_errx = (m_err >= 5) ? 1 : 0;
            if (cyc_start) m_err = (pred_err > 50) ? ((m_err < 5) ? m_err + 1 : 5) : 0;
            m_tickd = theta_tick;
            if (theta_tick)
                for (int i = 0; i < 4; i++) begin
                    if (ep_valid[i]) begin
                        m_conf[i] = (str(i) >= 6) ? 3 : (str(i) <= 5) ? ((m_conf[i] == 3) ? 2 : 1) : 2;
                        m_idle[i] = 0;
                    end else begin
`ifdef METACOG_DECAY_EN
                        m_idle[i]++;
                        if (m_idle[i] == 8) begin
                            m_idle[i] = 0;
                            if (m_conf[i] > 0) m_conf[i]--;
                        end
`endif
                    end
                end
        end
    end

    always @(negedge clk) begin
        int ec;
        if (started) begin
            ec = 0;
            for (int i = 0; i < 4; i++) ec += m_conf[i] << (2 * i);
            chk("mode", int'(mode), m_mode);
            chk("exploit_mode", int'(exploit_mode), (m_mode == 1) ? 1 : 0);
            chk("explore_mode", int'(explore_mode), (m_mode == 2) ? 1 : 0);
            chk("confidence_level", int'(confidence_level), ec);
            chk("err_explore", int'(err_explore), m_errx);
            chk("mode_change", int'(mode_change), m_mc);
            chk("worst_ch", int'(worst_ch), m_worst);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        theta_tick = 1'b1;
        step();
        theta_tick = 1'b0;
    endtask

    task automatic idle_evals();
        ep_valid = 4'h0;
        repeat (4) begin
            tick();
            step(2);
        end
    endtask

    initial begin
        rst_n = 1'b0; theta_tick = 1'b0; cyc_start = 1'b0; input_mismatch = 1'b0;
        ep_strength = '0; ep_valid = '0; pred_err = '0;
        step(2);
        chk("rst_mode", int'(mode), 0);
        chk("rst_conf", int'(confidence_level), 0);
        chk("rst_worst", int'(worst_ch), 0);
        chk("rst_mc", int'(mode_change), 0);
        rst_n = 1'b1;

        ep_valid = 4'hF;
        ep_strength = 16'h7777;
        tick();
        chk("conf_all3", int'(confidence_level), 8'hFF);
        step(2);
        repeat (2) begin
            tick();
            step(2);
        end
        chk("dwell_hold_neutral", int'(mode), 0);
        tick();
        step();
        chk("exploit_entry", int'(mode), 1);
        chk("exploit_pulse", int'(mode_change), 1);
        step();
        chk("exploit_pulse_end", int'(mode_change), 0);

        cyc_start = 1'b1;
        pred_err = 8'd60;
        step(5);
        cyc_start = 1'b0;
        chk("streak_pre", int'(mode), 1);
        step();
        chk("streak_errx", int'(err_explore), 1);
        chk("streak_mode", int'(mode), 2);
        chk("streak_pulse", int'(mode_change), 1);
        pred_err = 8'd40;
        cyc_start = 1'b1;
        step();
        cyc_start = 1'b0;
        pred_err = 8'd0;
        step();
        chk("streak_clear", int'(err_explore), 0);

        input_mismatch = 1'b1;
        step();
        input_mismatch = 1'b0;
        chk("force_in_explore_nopulse", int'(mode_change), 0);

        idle_evals();
        chk("back_to_neutral", int'(mode), 0);
        input_mismatch = 1'b1;
        step();
        input_mismatch = 1'b0;
        chk("mismatch_mode", int'(mode), 2);
        chk("mismatch_pulse", int'(mode_change), 1);
        step();

        idle_evals();
        chk("neutral_again", int'(mode), 0);
        ep_valid = 4'hF;
        ep_strength = 16'h7777;
        tick();
        step(2);
        ep_strength = 16'h3477;
        tick();
        chk("mixed_conf", int'(confidence_level), 8'hAF);
        step(2);
        chk("mixed_worst", int'(worst_ch), 3);
        tick();
        step(2);
        chk("mixed_hold", int'(mode), 0);
        tick();
        step();
        chk("vote_explore", int'(mode), 2);
        chk("vote_pulse", int'(mode_change), 1);
        step();
        ep_strength = 16'h9944;
        tick();
        step();
        chk("tie_worst", int'(worst_ch), 0);
        step();
        ep_valid = 4'b1100;
        ep_strength = 16'h5500;
        tick();
        step();
        chk("valid_mask_worst", int'(worst_ch), 2);
        step();

        theta_tick = 1'b1;
        cyc_start = 1'b1;
        pred_err = 8'd60;
        step();
        theta_tick = 1'b0;
        step();
        step();
        cyc_start = 1'b0;
        pred_err = 8'd0;
        step();
        chk("err3_no_force", int'(err_explore), 0);
        chk("err3_mode", int'(mode), 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_conf", int'(confidence_level), 0);
        chk("mid_rst_mc", int'(mode_change), 0);
        chk("mid_rst_errx", int'(err_explore), 0);
        cyc_start = 1'b1;
        pred_err = 8'd60;
        step(2);
        cyc_start = 1'b0;
        pred_err = 8'd0;
        step(2);
        chk("mid_rst_counter", int'(err_explore), 0);
        chk("mid_rst_counter_mode", int'(mode), 0);

        ep_valid = 4'hF;
        ep_strength = 16'h7777;
        tick();
        chk("decay_start", int'(confidence_level), 8'hFF);
        ep_valid = 4'b1110;
        repeat (8) tick();
`ifdef METACOG_DECAY_EN
        chk("decay_8", int'(confidence_level[1:0]), 2);
`else
        chk("decay_8", int'(confidence_level[1:0]), 3);
`endif
        repeat (16) tick();
`ifdef METACOG_DECAY_EN
        chk("decay_24", int'(confidence_level[1:0]), 0);
`else
        chk("decay_24", int'(confidence_level[1:0]), 3);
`endif

        for (int k = 0; k < 80; k++) begin
            theta_tick = ($urandom_range(0, 2) == 0);
            cyc_start = ($urandom_range(0, 1) == 0);
            pred_err = 8'($urandom_range(30, 90));
            input_mismatch = ($urandom_range(0, 19) == 0);
            ep_valid = 4'($urandom_range(0, 15));
            ep_strength = 16'($urandom);
            step();
        end
        theta_tick = 1'b0; cyc_start = 1'b0; input_mismatch = 1'b0;
        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
